// File: rtl/mips_isa_pkg.sv
// Shared MIPS ISA definitions: the mnemonic codes, opcode/funct values and
// instruction field positions used by both the encoder and the decoder.
package mips_isa_pkg;

  typedef enum logic [4:0] {
    MN_ADD   = 5'd0,
    MN_ADDU  = 5'd1,
    MN_SUB   = 5'd2,
    MN_SUBU  = 5'd3,
    MN_AND   = 5'd4,
    MN_OR    = 5'd5,
    MN_NOR   = 5'd6,
    MN_SLT   = 5'd7,
    MN_SLTU  = 5'd8,
    MN_SLL   = 5'd9,
    MN_SRL   = 5'd10,
    MN_JR    = 5'd11,
    MN_ADDI  = 5'd12,
    MN_ADDIU = 5'd13,
    MN_SLTI  = 5'd14,
    MN_SLTIU = 5'd15,
    MN_ANDI  = 5'd16,
    MN_ORI   = 5'd17,
    MN_LUI   = 5'd18,
    MN_BEQ   = 5'd19,
    MN_BNE   = 5'd20,
    MN_LW    = 5'd21,
    MN_LBU   = 5'd22,
    MN_LHU   = 5'd23,
    MN_SB    = 5'd24,
    MN_SH    = 5'd25,
    MN_SW    = 5'd26,
    MN_J     = 5'd27,
    MN_JAL   = 5'd28
  } mnemonic_e;

  typedef enum logic [1:0] {
    FMT_R,
    FMT_I,
    FMT_J
  } fmt_e;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_JAL   = 6'h03;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_BNE   = 6'h05;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_SLTIU = 6'h0B;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_LUI   = 6'h0F;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_LBU   = 6'h24;
  localparam logic [5:0] OPC_LHU   = 6'h25;
  localparam logic [5:0] OPC_SB    = 6'h28;
  localparam logic [5:0] OPC_SH    = 6'h29;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_JR   = 6'h08;
  localparam logic [5:0] FN_ADD  = 6'h20;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUB  = 6'h22;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  localparam int unsigned OP_LSB    = 26;
  localparam int unsigned RS_LSB    = 21;
  localparam int unsigned RT_LSB    = 16;
  localparam int unsigned RD_LSB    = 11;
  localparam int unsigned SHAMT_LSB = 6;
  localparam int unsigned FUNCT_LSB = 0;

endpackage

// File: rtl/mips_encode_word.sv
// Combinational mnemonic + fields -> canonical 32-bit MIPS word.
module mips_encode_word
  import mips_isa_pkg::*;
(
  input  logic [4:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  shamt_i,
  input  logic [15:0] imm_i,
  input  logic [25:0] target_i,
  output logic [31:0] word_o,
  output logic        legal_o
);

  mnemonic_e  mn;
  fmt_e       fmt;
  logic [5:0] opc;
  logic [5:0] fn;
  logic [4:0] rs;
  logic [4:0] rt;
  logic [4:0] rd;
  logic [4:0] sh;

  assign mn = mnemonic_e'(op_i);

  // Unused fields default to the caller's value; shamt defaults to zero so
  // only the shifts need to pass it through.
  always_comb begin
    fmt     = FMT_R;
    opc     = OPC_RTYPE;
    fn      = '0;
    rs      = rs_i;
    rt      = rt_i;
    rd      = rd_i;
    sh      = '0;
    legal_o = 1'b1;
    case (mn)
      MN_ADD:   fn = FN_ADD;
      MN_ADDU:  fn = FN_ADDU;
      MN_SUB:   fn = FN_SUB;
      MN_SUBU:  fn = FN_SUBU;
      MN_AND:   fn = FN_AND;
      MN_OR:    fn = FN_OR;
      MN_NOR:   fn = FN_NOR;
      MN_SLT:   fn = FN_SLT;
      MN_SLTU:  fn = FN_SLTU;
      MN_SLL:   begin fn = FN_SLL; rs = '0; sh = shamt_i; end
      MN_SRL:   begin fn = FN_SRL; rs = '0; sh = shamt_i; end
      MN_JR:    begin fn = FN_JR;  rt = '0; rd = '0; end
      MN_ADDI:  begin fmt = FMT_I; opc = OPC_ADDI;  end
      MN_ADDIU: begin fmt = FMT_I; opc = OPC_ADDIU; end
      MN_SLTI:  begin fmt = FMT_I; opc = OPC_SLTI;  end
      MN_SLTIU: begin fmt = FMT_I; opc = OPC_SLTIU; end
      MN_ANDI:  begin fmt = FMT_I; opc = OPC_ANDI;  end
      MN_ORI:   begin fmt = FMT_I; opc = OPC_ORI;   end
      MN_LUI:   begin fmt = FMT_I; opc = OPC_LUI; rs = '0; end
      MN_BEQ:   begin fmt = FMT_I; opc = OPC_BEQ;   end
      MN_BNE:   begin fmt = FMT_I; opc = OPC_BNE;   end
      MN_LW:    begin fmt = FMT_I; opc = OPC_LW;    end
      MN_LBU:   begin fmt = FMT_I; opc = OPC_LBU;   end
      MN_LHU:   begin fmt = FMT_I; opc = OPC_LHU;   end
      MN_SB:    begin fmt = FMT_I; opc = OPC_SB;    end
      MN_SH:    begin fmt = FMT_I; opc = OPC_SH;    end
      MN_SW:    begin fmt = FMT_I; opc = OPC_SW;    end
      MN_J:     begin fmt = FMT_J; opc = OPC_J;     end
      MN_JAL:   begin fmt = FMT_J; opc = OPC_JAL;   end
      default:  legal_o = 1'b0;
    endcase
  end

  always_comb begin
    word_o = '0;
    if (legal_o) begin
      case (fmt)
        FMT_I: word_o = (32'(opc) << OP_LSB) | (32'(rs) << RS_LSB) |
                        (32'(rt) << RT_LSB) | 32'(imm_i);
        FMT_J: word_o = (32'(opc) << OP_LSB) | 32'(target_i);
        default: word_o = (32'(opc) << OP_LSB) | (32'(rs) << RS_LSB) |
                          (32'(rt) << RT_LSB) | (32'(rd) << RD_LSB) |
                          (32'(sh) << SHAMT_LSB) | (32'(fn) << FUNCT_LSB);
      endcase
    end
  end

endmodule

// File: rtl/mips_instr_encoder.sv
// Mnemonic-level instruction encoder: buffers requests in a 2-entry FIFO and
// issues encoded words to sequential instruction-memory addresses.
module mips_instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int unsigned           ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]     RESET_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              addr_load,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_shamt,
  input  logic [15:0]       in_imm,
  input  logic [25:0]       in_target,
  output logic              wr_valid,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              err_illegal,
  output logic [15:0]       word_count
);

  logic [31:0]       enc_word;
  logic              enc_legal;

  logic [1:0]        count_q, count_d;
  logic [ADDR_W-1:0] ent_addr_q [2];
  logic [ADDR_W-1:0] ent_addr_d [2];
  logic [31:0]       ent_data_q [2];
  logic [31:0]       ent_data_d [2];
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              in_ready_q, in_ready_d;
  logic              err_q, err_d;
  logic [15:0]       word_count_q, word_count_d;

  logic              accept, push, pop;
  logic [ADDR_W-1:0] base;

  mips_encode_word u_enc (
    .op_i     (in_op),
    .rs_i     (in_rs),
    .rt_i     (in_rt),
    .rd_i     (in_rd),
    .shamt_i  (in_shamt),
    .imm_i    (in_imm),
    .target_i (in_target),
    .word_o   (enc_word),
    .legal_o  (enc_legal)
  );

  // Shift-register FIFO: entry 0 is always the head, so a pop moves entry 1
  // down and a push lands in the first slot left free after that move.
  always_comb begin
    accept        = in_valid & in_ready_q;
    push          = accept & enc_legal;
    pop           = (count_q != 2'd0) & wr_ready;
    base          = addr_load ? (addr_in & ~ADDR_W'(3)) : addr_q;
    addr_d        = push ? base + ADDR_W'(4) : base;
    count_d       = count_q + 2'(push) - 2'(pop);
    in_ready_d    = (count_d != 2'd2);
    err_d         = accept & ~enc_legal;
    word_count_d  = word_count_q + 16'(push);
    ent_addr_d[0] = ent_addr_q[0];
    ent_addr_d[1] = ent_addr_q[1];
    ent_data_d[0] = ent_data_q[0];
    ent_data_d[1] = ent_data_q[1];
    if (pop) begin
      ent_addr_d[0] = ent_addr_q[1];
      ent_data_d[0] = ent_data_q[1];
    end
    if (push) begin
      if ((count_q - 2'(pop)) == 2'd0) begin
        ent_addr_d[0] = base;
        ent_data_d[0] = enc_word;
      end else begin
        ent_addr_d[1] = base;
        ent_data_d[1] = enc_word;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      ent_addr_q[0] <= '0;
      ent_addr_q[1] <= '0;
      ent_data_q[0] <= '0;
      ent_data_q[1] <= '0;
      addr_q        <= RESET_ADDR;
      in_ready_q    <= 1'b1;
      err_q         <= 1'b0;
      word_count_q  <= '0;
    end else begin
      count_q       <= count_d;
      ent_addr_q[0] <= ent_addr_d[0];
      ent_addr_q[1] <= ent_addr_d[1];
      ent_data_q[0] <= ent_data_d[0];
      ent_data_q[1] <= ent_data_d[1];
      addr_q        <= addr_d;
      in_ready_q    <= in_ready_d;
      err_q         <= err_d;
      word_count_q  <= word_count_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign wr_valid    = (count_q != 2'd0);
  assign wr_addr     = ent_addr_q[0];
  assign wr_data     = ent_data_q[0];
  assign err_illegal = err_q;
  assign word_count  = word_count_q;

endmodule

// File: tb/tb_mips_instr_encoder.sv
// Self-checking bench for mips_instr_encoder: directed encodings, backpressure,
// illegal ops, mid-run reset and randomized traffic against a queue model.
module tb_mips_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        addr_load;
  logic [31:0] addr_in;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_op;
  logic [4:0]  in_rs, in_rt, in_rd, in_shamt;
  logic [15:0] in_imm;
  logic [25:0] in_target;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        err_illegal;
  logic [15:0] word_count;

  int unsigned errors = 0;
  int unsigned checks = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;
  ent_t        mq[$];
  logic [31:0] m_addr;
  logic [15:0] m_cnt;
  logic        m_err;

  always #5 clk = ~clk;

  mips_instr_encoder #(.ADDR_W(32), .RESET_ADDR(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .addr_load(addr_load), .addr_in(addr_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_rs(in_rs),
    .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt), .in_imm(in_imm),
    .in_target(in_target), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data), .err_illegal(err_illegal),
    .word_count(word_count)
  );

  // Reference encoding from the instruction tables: {legal, word}.
  function automatic logic [32:0] ref_enc(input int op, input int rs, input int rt,
                                          input int rd, input int sh, input int imm,
                                          input int tgt);
    int rfn[12] = '{32, 33, 34, 35, 36, 37, 39, 42, 43, 0, 2, 8};
    int iop[15] = '{8, 9, 10, 11, 12, 13, 15, 4, 5, 35, 36, 37, 40, 41, 43};
    logic [31:0] w;
    if (op < 12) begin
      if (op == 9 || op == 10) rs = 0;
      else sh = 0;
      if (op == 11) begin rt = 0; rd = 0; end
      w = 32'(rs) * 32'h200000 + 32'(rt) * 32'h10000 + 32'(rd) * 32'h800 +
          32'(sh) * 32'h40 + 32'(rfn[op]);
      return {1'b1, w};
    end else if (op < 27) begin
      if (op == 18) rs = 0;
      w = 32'(iop[op-12]) * 32'h4000000 + 32'(rs) * 32'h200000 +
          32'(rt) * 32'h10000 + 32'(imm);
      return {1'b1, w};
    end else if (op < 29) begin
      w = 32'(op - 25) * 32'h4000000 + 32'(tgt);
      return {1'b1, w};
    end
    return {1'b0, 32'h0};
  endfunction

  task automatic model_reset();
    mq.delete();
    m_addr = 32'h0;
    m_cnt  = 16'h0;
    m_err  = 1'b0;
  endtask

  // Advances the model by one clock using the inputs as currently driven.
  task automatic model_cycle();
    bit          acc, pop;
    logic [31:0] base;
    logic [32:0] e;
    ent_t        n;
    acc  = in_valid && (mq.size() < 2);
    pop  = (mq.size() > 0) && wr_ready;
    base = addr_load ? {addr_in[31:2], 2'b00} : m_addr;
    e    = ref_enc(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd),
                   int'(in_shamt), int'(in_imm), int'(in_target));
    if (pop) void'(mq.pop_front());
    m_err  = acc && !e[32];
    m_addr = base;
    if (acc && e[32]) begin
      n.a = base;
      n.d = e[31:0];
      mq.push_back(n);
      m_addr = base + 32'd4;
      m_cnt  = m_cnt + 16'd1;
    end
  endtask

  task automatic tick();
    model_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; addr_load = 0; addr_in = '0; in_op = '0; in_rs = '0;
    in_rt = '0; in_rd = '0; in_shamt = '0; in_imm = '0; in_target = '0;
  endtask

  task automatic drive(input int op, input int rs, input int rt, input int rd,
                       input int sh, input int imm, input int tgt);
    in_valid = 1; in_op = 5'(op); in_rs = 5'(rs); in_rt = 5'(rt); in_rd = 5'(rd);
    in_shamt = 5'(sh); in_imm = 16'(imm); in_target = 26'(tgt);
  endtask

  task automatic do_reset();
    idle_inputs();
    wr_ready = 0;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    model_reset();
  endtask

  task automatic test_reset();
    idle_inputs();
    wr_ready = 0;
    rst_n = 0;
    #12;
    checks++;
    if ({wr_valid, wr_addr, wr_data, err_illegal, word_count} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%0b a=%h d=%h err=%0b cnt=%0d want all zero",
               wr_valid, wr_addr, wr_data, err_illegal, word_count);
    end
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    #2;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %0b want 1", in_ready);
    end
  endtask

  task automatic test_encode();
    logic [31:0] exp_a [6] = '{32'h0, 32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};
    logic [31:0] exp_d [6] = '{32'h00221820, 32'h20080005, 32'h8FA90004,
                                32'h00031100, 32'h08000010, 32'h1022FFFF};
    do_reset();
    wr_ready = 1;
    for (int unsigned i = 0; i < 6; i++) begin
      case (i)
        0: drive(0, 1, 2, 3, 5, 0, 0);
        1: drive(12, 0, 8, 0, 0, 16'h0005, 0);
        2: drive(21, 29, 9, 0, 0, 16'h0004, 0);
        3: drive(9, 7, 3, 2, 4, 0, 0);
        4: drive(27, 0, 0, 0, 0, 0, 26'h10);
        default: drive(19, 1, 2, 0, 0, 16'hFFFF, 0);
      endcase
      tick();
      checks++;
      if ({wr_valid, wr_addr, wr_data} !== {1'b1, exp_a[i], exp_d[i]}) begin
        errors++;
        $display("FAIL encode_%0d: got v=%0b a=%h d=%h want v=1 a=%h d=%h",
                 i, wr_valid, wr_addr, wr_data, exp_a[i], exp_d[i]);
      end
      if (i == 0) begin
        in_valid = 0;
        addr_load = 1;
        addr_in = 32'h103;
        tick();
        addr_load = 0;
      end
    end
    in_valid = 0;
    tick();
    checks++;
    if ({wr_valid, word_count} !== {1'b0, 16'd6}) begin
      errors++;
      $display("FAIL encode_drain: got v=%0b cnt=%0d want v=0 cnt=6", wr_valid, word_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    wr_ready = 0;
    for (int unsigned i = 1; i <= 3; i++) begin
      drive(13, 0, 1, 0, 0, int'(i), 0);
      tick();
      checks++;
      if ({in_ready, wr_valid, wr_addr, wr_data} !== {(i == 1), 1'b1, 32'h0, 32'h24010001}) begin
        errors++;
        $display("FAIL bp_hold_%0d: got rdy=%0b v=%0b a=%h d=%h want rdy=%0b v=1 a=0 d=24010001",
                 i, in_ready, wr_valid, wr_addr, wr_data, (i == 1));
      end
    end
    wr_ready = 1;
    for (int unsigned i = 2; i <= 3; i++) begin
      tick();
      checks++;
      if ({in_ready, wr_valid, wr_addr, wr_data} !==
          {1'b1, 1'b1, 32'(4 * (i - 1)), 32'h24010000 + 32'(i)}) begin
        errors++;
        $display("FAIL bp_drain_%0d: got rdy=%0b v=%0b a=%h d=%h want rdy=1 v=1 a=%h d=%h",
                 i, in_ready, wr_valid, wr_addr, wr_data, 4 * (i - 1), 32'h24010000 + i);
      end
    end
    in_valid = 0;
    tick();
    checks++;
    if ({wr_valid, word_count} !== {1'b0, 16'd3}) begin
      errors++;
      $display("FAIL bp_count: got v=%0b cnt=%0d want v=0 cnt=3", wr_valid, word_count);
    end
  endtask

  task automatic test_illegal();
    drive(30, 1, 2, 3, 4, 5, 6);
    tick();
    in_valid = 0;
    checks++;
    if ({err_illegal, wr_valid, word_count} !== {1'b1, 1'b0, 16'd3}) begin
      errors++;
      $display("FAIL illegal_pulse: got err=%0b v=%0b cnt=%0d want err=1 v=0 cnt=3",
               err_illegal, wr_valid, word_count);
    end
    tick();
    checks++;
    if (err_illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear: got err=%0b want 0", err_illegal);
    end
    drive(13, 0, 1, 0, 0, 7, 0);
    tick();
    in_valid = 0;
    checks++;
    if ({wr_valid, wr_addr, wr_data} !== {1'b1, 32'hC, 32'h24010007}) begin
      errors++;
      $display("FAIL illegal_addr: got v=%0b a=%h d=%h want v=1 a=c d=24010007",
               wr_valid, wr_addr, wr_data);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    wr_ready = 0;
    drive(13, 0, 1, 0, 0, 1, 0);
    tick();
    tick();
    in_valid = 0;
    checks++;
    if ({in_ready, wr_valid} !== 2'b01) begin
      errors++;
      $display("FAIL mid_full: got rdy=%0b v=%0b want rdy=0 v=1", in_ready, wr_valid);
    end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({wr_valid, wr_data} !== '0) begin
      errors++;
      $display("FAIL mid_flush: got v=%0b d=%h want v=0 d=0", wr_valid, wr_data);
    end
    @(posedge clk);
    #1 rst_n = 1;
    model_reset();
    wr_ready = 1;
    drive(13, 0, 1, 0, 0, 9, 0);
    tick();
    in_valid = 0;
    checks++;
    if ({wr_valid, wr_addr, wr_data, word_count} !== {1'b1, 32'h0, 32'h24010009, 16'd1}) begin
      errors++;
      $display("FAIL mid_restart: got v=%0b a=%h d=%h cnt=%0d want v=1 a=0 d=24010009 cnt=1",
               wr_valid, wr_addr, wr_data, word_count);
    end
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int unsigned c = 0; c < 600; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_op     = 5'($urandom);
      in_rs     = 5'($urandom);
      in_rt     = 5'($urandom);
      in_rd     = 5'($urandom);
      in_shamt  = 5'($urandom);
      in_imm    = 16'($urandom);
      in_target = 26'($urandom);
      addr_load = ($urandom_range(0, 19) == 0);
      addr_in   = $urandom;
      wr_ready  = ($urandom_range(0, 9) < 6);
      tick();
      checks++;
      if ({in_ready, wr_valid, err_illegal, word_count} !==
          {(mq.size() < 2), (mq.size() > 0), m_err, m_cnt}) begin
        errors++;
        $display("FAIL rand_ctrl c=%0d: got rdy=%0b v=%0b err=%0b cnt=%0d want rdy=%0b v=%0b err=%0b cnt=%0d",
                 c, in_ready, wr_valid, err_illegal, word_count,
                 (mq.size() < 2), (mq.size() > 0), m_err, m_cnt);
      end
      if (mq.size() > 0) begin
        checks++;
        if ({wr_addr, wr_data} !== {mq[0].a, mq[0].d}) begin
          errors++;
          $display("FAIL rand_head c=%0d: got a=%h d=%h want a=%h d=%h",
                   c, wr_addr, wr_data, mq[0].a, mq[0].d);
        end
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_encode();
    test_backpressure();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_instr_encoder.md
Name: mips_instr_encoder

Overview:
Encodes one mnemonic-level instruction request per cycle into a 32-bit MIPS word and writes it sequentially into instruction memory. It runs in the opposite direction to the opcode/funct decoder that drives the core's control signals, and supports the same instruction subset. It sits between the testbench/program source and the instruction-memory write port. Requests are buffered in a 2-entry FIFO, with valid/ready handshakes on both sides.

Parameters:
ADDR_W, 32, width of the byte address issued to instruction memory
RESET_ADDR, 0, value of the write-address counter after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
addr_load  in  1  load the write-address counter from addr_in
addr_in  in  ADDR_W  new base byte address; bits [1:0] are ignored and forced to 0
in_valid  in  1  request valid
in_ready  out  1  request accepted when in_valid and in_ready are both high
in_op  in  5  mnemonic code (shared package enum)
in_rs  in  5  rs field
in_rt  in  5  rt field
in_rd  in  5  rd field
in_shamt  in  5  shamt field
in_imm  in  16  immediate field
in_target  in  26  jump target field
wr_valid  out  1  memory write valid
wr_ready  in  1  memory accepts the write when wr_valid and wr_ready are both high
wr_addr  out  ADDR_W  byte address of the word
wr_data  out  32  encoded instruction word
err_illegal  out  1  one-cycle pulse: an illegal in_op was accepted and dropped
word_count  out  16  legal words accepted since reset; wraps

Behaviour:
- Reset (async, rst_n=0): FIFO empty; wr_valid=0, wr_addr=0, wr_data=0, err_illegal=0, word_count=0; address counter=RESET_ADDR; in_ready=1 as soon as reset is released.
- Handshake:
  - in_ready = (FIFO occupancy < 2), registered.
  - wr_valid = FIFO not empty.
  - wr_addr/wr_data come from the FIFO head and stay stable while wr_valid=1 and wr_ready=0.
  - Pop on wr_valid & wr_ready.
- Latency: a request accepted at edge N with the FIFO empty gives wr_valid=1 after edge N.
- Throughput: with wr_ready held at 1, one word per cycle sustained.
- Full FIFO: in_ready=0, so a push in the same cycle as a pop cannot happen. in_ready returns to 1 the cycle after a pop.
- Address assignment:
  - The address is captured into the FIFO entry at acceptance time.
  - The counter advances by 4 per accepted legal request and wraps mod 2^ADDR_W.
  - addr_load in the same cycle as an acceptance: the accepted word takes {addr_in[ADDR_W-1:2],2'b00} and the counter becomes that value + 4.
  - addr_load alone: counter = {addr_in[ADDR_W-1:2],2'b00}.
  - Entries already in the FIFO are unaffected.
- Encoding, R-type (opcode 0x00, funct per mnemonic):
  - ADD 20, ADDU 21, SUB 22, SUBU 23, AND 24, OR 25, NOR 27, SLT 2A, SLTU 2B, SLL 00, SRL 02, JR 08.
- Encoding, I-type (opcode per mnemonic, word = {op, rs, rt, imm}):
  - ADDI 08, ADDIU 09, SLTI 0A, SLTIU 0B, ANDI 0C, ORI 0D, LUI 0F, BEQ 04, BNE 05, LW 23, LBU 24, LHU 25, SB 28, SH 29, SW 2B.
- Encoding, J-type: J 02, JAL 03; word = {op, target}.
- Field forcing (canonical encoding):
  - SLL/SRL: rs=0.
  - Other R-type: shamt=0.
  - JR: rt=rd=shamt=0.
  - LUI: rs=0.
- Illegal in_op (codes 29-31):
  - The request is accepted (it obeys in_ready) but nothing is pushed.
  - The counter and word_count do not change.
  - err_illegal pulses high the following cycle.
- Reset mid-operation: the FIFO is flushed and any pending write is lost; no partial write is issued.

Decomposition:
- Package mips_isa_pkg:
  - mnemonic enum (ADD=0 ... JAL=28, 29-31 reserved).
  - opcode and funct localparams shared with the decoder.
  - Field bit-position constants.
- Sub-module mips_encode_word: purely combinational {op, fields} -> {word, legal}.
- The FIFO and counters live in the top module.

Test Plan:
- ADD rd=3 rs=1 rt=2 shamt=5, wr_ready=1 -> wr_data=0x00221820, wr_addr=0x0, shamt forced to 0.
- After addr_load addr_in=0x103: ADDI rt=8 rs=0 imm=0x0005 -> 0x20080005 @0x100; then LW rt=9 rs=29 imm=0x0004 -> 0x8FA90004 @0x104.
- SLL rd=2 rt=3 shamt=4 rs=7 -> 0x00031100 (rs forced 0).
- J target=0x0000010 -> 0x08000010; BEQ rs=1 rt=2 imm=0xFFFF -> 0x1022FFFF.
- Backpressure:
  - Stimulus: wr_ready=0 with 3 back-to-back requests.
  - Response: in_ready drops after the 2nd acceptance and the head stays stable.
  - Then raise wr_ready: 3 writes in order at consecutive addresses, word_count=3.
- Illegal and reset:
  - in_op=30 -> err_illegal pulse, no write, counter unchanged.
  - rst_n low while the FIFO is full -> wr_valid=0 immediately; after release, addr=RESET_ADDR.
